// File: rtl/obj_pkg.sv
// Shared types and constants for the OBJ attribute memory (OAM) port.
package obj_pkg;

    localparam int OAM_WORDS = 256;

    typedef enum logic [1:0] {
        OAM_BYTE = 2'd0,
        OAM_HALF = 2'd1,
        OAM_WORD = 2'd2,
        OAM_RSVD = 2'd3
    } oam_size_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } oam_state_t;

    // Byte-lane write mask for a CPU store. Byte and reserved sizes yield an
    // empty mask: OAM ignores byte stores, so those writes are dropped.
    function automatic logic [3:0] oam_lane_mask(input oam_size_t size, input logic half_hi);
        logic [3:0] mask;
        case (size)
            OAM_WORD: mask = 4'b1111;
            OAM_HALF: mask = half_hi ? 4'b1100 : 4'b0011;
            default:  mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/obj_oam_ram.sv
// Single-port 256x32 OAM array: byte-enable write, registered read.
module obj_oam_ram
    import obj_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        re_i,
    input  logic [3:0]  be_i,
    input  logic [7:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o
);

    logic [31:0] mem_q [OAM_WORDS];
    logic [31:0] rdata_q;

    // Byte-lane write into the array; contents survive reset.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (be_i[b]) begin
                mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    // Read register: loads only when a read is issued, otherwise holds.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rdata_q <= 32'h0000_0000;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/obj_oam_port.sv
// OAM responder: graphics reads have absolute priority on the single RAM
// port; CPU accesses are serialised by an IDLE/ACCESS/DONE handshake FSM.
module obj_oam_port
    import obj_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        gfx_rd,
    input  logic [7:0]  gfx_addr,
    output logic [31:0] gfx_data,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [9:0]  cpu_addr,
    input  logic [1:0]  cpu_size,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_dropped
);

    oam_state_t  state_q, state_d;
    logic [9:1]  addr_q, addr_d;
    logic        we_q, we_d;
    oam_size_t   size_q, size_d;
    logic [31:0] wdata_q, wdata_d;

    logic        ack_q, ack_d;
    logic        dropped_q, dropped_d;
    logic        gfx_fresh_q, cpu_fresh_q;
    logic [31:0] gfx_hold_q, cpu_hold_q;

    logic        access_go_s;
    logic [3:0]  lane_mask_s;
    logic        ram_re_s;
    logic [3:0]  ram_be_s;
    logic [7:0]  ram_addr_s;
    logic [31:0] ram_rdata_s;

    // Byte offset bit 0 never matters: halfwords are lane-pair aligned.
    logic        unused_addr0_s;
    assign unused_addr0_s = cpu_addr[0];

    // The CPU operation happens in the first ACCESS cycle free of graphics.
    assign access_go_s = (state_q == ACCESS) && !gfx_rd;
    assign lane_mask_s = oam_lane_mask(size_q, addr_q[1]);

    // Next state and request latch; the request is captured only on IDLE->ACCESS.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    state_d = ACCESS;
                    addr_d  = cpu_addr[9:1];
                    we_d    = cpu_we;
                    size_d  = oam_size_t'(cpu_size);
                    wdata_d = cpu_wdata;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (gfx_rd) begin
                    state_d = ACCESS;
                end else begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // RAM port mux: graphics wins outright; the CPU uses idle slots only.
    always_comb begin
        ram_addr_s = addr_q[9:2];
        ram_re_s   = 1'b0;
        ram_be_s   = 4'b0000;
        if (gfx_rd) begin
            ram_addr_s = gfx_addr;
            ram_re_s   = 1'b1;
        end else if (access_go_s) begin
            if (we_q) begin
                ram_be_s = lane_mask_s;
            end else begin
                ram_re_s = 1'b1;
            end
        end else begin
            ram_re_s = 1'b0;
        end
    end

    // Completion pulses are registered so they appear during DONE.
    always_comb begin
        ack_d     = access_go_s;
        dropped_d = access_go_s && we_q && (lane_mask_s == 4'b0000);
    end

    // FSM state and latched request registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= 9'h000;
            we_q    <= 1'b0;
            size_q  <= OAM_BYTE;
            wdata_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
        end
    end

    // Handshake pulses and which requester owns the RAM read register next cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ack_q       <= 1'b0;
            dropped_q   <= 1'b0;
            gfx_fresh_q <= 1'b0;
            cpu_fresh_q <= 1'b0;
        end else begin
            ack_q       <= ack_d;
            dropped_q   <= dropped_d;
            gfx_fresh_q <= gfx_rd;
            cpu_fresh_q <= access_go_s && !we_q;
        end
    end

    // Hold registers keep each requester's last result while the shared
    // read register is reused by the other side.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gfx_hold_q <= 32'h0000_0000;
            cpu_hold_q <= 32'h0000_0000;
        end else begin
            gfx_hold_q <= gfx_data;
            cpu_hold_q <= cpu_rdata;
        end
    end

    assign gfx_data    = gfx_fresh_q ? ram_rdata_s : gfx_hold_q;
    assign cpu_rdata   = cpu_fresh_q ? ram_rdata_s : cpu_hold_q;
    assign cpu_ack     = ack_q;
    assign cpu_dropped = dropped_q;

    obj_oam_ram u_ram (
        .clk_i   (clock),
        .rst_n_i (reset),
        .re_i    (ram_re_s),
        .be_i    (ram_be_s),
        .addr_i  (ram_addr_s),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata_s)
    );

endmodule

// File: tb/tb_obj_oam_port.sv
// Scoreboard bench for obj_oam_port: stimulus pushes expectations, a
// negedge monitor pops and compares whenever gfx data or cpu_ack is due.
module tb_obj_oam_port;

    logic        clock;
    logic        reset;
    logic        gfx_rd;
    logic [7:0]  gfx_addr;
    logic [31:0] gfx_data;
    logic        cpu_req;
    logic        cpu_we;
    logic [9:0]  cpu_addr;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ack;
    logic        cpu_dropped;

    typedef struct {
        int          ack_cyc;
        logic        dropped;
        logic        chk_rd;
        logic [31:0] rdata;
    } cpu_exp_t;

    logic [31:0] gfx_q [$];
    cpu_exp_t    cpu_q [$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic gfx_due = 1'b0;

    logic [7:0]  cont_addr [5] = '{8'h14, 8'h04, 8'h14, 8'h0C, 8'h14};
    logic [31:0] cont_exp  [5] = '{32'hCAFE_0001, 32'hDEAD_BEEF, 32'hCAFE_0001,
                                   32'h1122_3344, 32'hCAFE_0001};

    obj_oam_port dut (
        .clock       (clock),
        .reset       (reset),
        .gfx_rd      (gfx_rd),
        .gfx_addr    (gfx_addr),
        .gfx_data    (gfx_data),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_size    (cpu_size),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_ack     (cpu_ack),
        .cpu_dropped (cpu_dropped)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cycle counter and record of gfx_rd as the DUT samples it.
    initial begin
        forever begin
            @(posedge clock);
            gfx_due = gfx_rd;
            cyc++;
        end
    end

    // Monitor: pops expectations when the DUT presents data or an ack.
    initial begin
        logic [31:0] ge;
        cpu_exp_t    ce;
        forever begin
            @(negedge clock);
            if (gfx_due) begin
                if (gfx_q.size() == 0) begin
                    chk("gfx_unexpected", 32'd1, 32'd0);
                end else begin
                    ge = gfx_q.pop_front();
                    chk("gfx_data", gfx_data, ge);
                end
            end
            if (cpu_ack) begin
                if (cpu_q.size() == 0) begin
                    chk("ack_unexpected", 32'd1, 32'd0);
                end else begin
                    ce = cpu_q.pop_front();
                    chk("ack_cycle", 32'(cyc), 32'(ce.ack_cyc));
                    chk("cpu_dropped", {31'd0, cpu_dropped}, {31'd0, ce.dropped});
                    if (ce.chk_rd) chk("cpu_rdata", cpu_rdata, ce.rdata);
                end
            end else if (cpu_dropped) begin
                chk("dropped_without_ack", {31'd0, cpu_ack}, 32'd1);
            end
        end
    end

    task automatic wait_ack();
        logic got;
        got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clock); #1;
            if (cpu_ack) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("ack_timeout", 32'd0, 32'd1);
        cpu_req = 1'b0;
    endtask

    // One CPU access; inputs are scrambled once latched to prove they are ignored.
    task automatic cpu_access(input logic we, input logic [1:0] size, input logic [9:0] addr,
                              input logic [31:0] wdata, input logic exp_drop,
                              input logic chk_rd, input logic [31:0] exp_rd);
        @(posedge clock); #1;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_size  = size;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_q.push_back('{cyc + 2, exp_drop, chk_rd, exp_rd});
        @(posedge clock); #1;
        cpu_we    = ~we;
        cpu_size  = ~size;
        cpu_addr  = ~addr;
        cpu_wdata = ~wdata;
        if (cpu_ack) chk("ack_too_early", 32'd1, 32'd0);
        wait_ack();
    endtask

    task automatic gfx_read(input logic [7:0] addr, input logic [31:0] exp);
        @(posedge clock); #1;
        gfx_rd   = 1'b1;
        gfx_addr = addr;
        gfx_q.push_back(exp);
        @(posedge clock); #1;
        gfx_rd   = 1'b0;
    endtask

    initial begin
        reset = 1'b0; gfx_rd = 1'b0; gfx_addr = 8'h00;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 10'h000; cpu_size = 2'd0; cpu_wdata = 32'h0;

        // Outputs during power-on reset.
        repeat (3) @(posedge clock); #1;
        chk("rst_gfx_data", gfx_data, 32'h0);
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        chk("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
        chk("rst_cpu_dropped", {31'd0, cpu_dropped}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;

        // Word write then graphics read.
        cpu_access(1'b1, 2'd2, 10'h010, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        gfx_read(8'h04, 32'hDEAD_BEEF);

        // Halfword lanes, upper pair then lower pair.
        cpu_access(1'b1, 2'd2, 10'h020, 32'h0000_0000, 1'b0, 1'b0, 32'h0);
        cpu_access(1'b1, 2'd1, 10'h022, 32'h1234_0000, 1'b0, 1'b0, 32'h0);
        gfx_read(8'h08, 32'h1234_0000);
        cpu_access(1'b1, 2'd1, 10'h023, 32'hABCD_0000, 1'b0, 1'b0, 32'h0);
        gfx_read(8'h08, 32'hABCD_0000);
        cpu_access(1'b0, 2'd2, 10'h020, 32'h0, 1'b0, 1'b1, 32'hABCD_0000);
        cpu_access(1'b0, 2'd3, 10'h021, 32'h0, 1'b0, 1'b1, 32'hABCD_0000);
        cpu_access(1'b1, 2'd1, 10'h020, 32'h0000_5678, 1'b0, 1'b0, 32'h0);
        cpu_access(1'b0, 2'd0, 10'h022, 32'h0, 1'b0, 1'b1, 32'hABCD_5678);

        // Byte and reserved-size writes are dropped.
        cpu_access(1'b1, 2'd2, 10'h030, 32'h1122_3344, 1'b0, 1'b0, 32'h0);
        cpu_access(1'b1, 2'd0, 10'h030, 32'h0000_00FF, 1'b1, 1'b0, 32'h0);
        cpu_access(1'b1, 2'd3, 10'h030, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0);
        gfx_read(8'h0C, 32'h1122_3344);
        cpu_access(1'b0, 2'd2, 10'h030, 32'h0, 1'b0, 1'b1, 32'h1122_3344);

        // Each side's output holds while the other side uses the RAM.
        gfx_read(8'h04, 32'hDEAD_BEEF);
        cpu_access(1'b0, 2'd2, 10'h030, 32'h0, 1'b0, 1'b1, 32'h1122_3344);
        chk("gfx_hold", gfx_data, 32'hDEAD_BEEF);
        gfx_read(8'h04, 32'hDEAD_BEEF);
        chk("cpu_rdata_hold", cpu_rdata, 32'h1122_3344);

        // Contention: five graphics cycles stall a held CPU write to word 0x14.
        cpu_access(1'b1, 2'd2, 10'h050, 32'hCAFE_0001, 1'b0, 1'b0, 32'h0);
        @(posedge clock); #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 2'd2; cpu_addr = 10'h050; cpu_wdata = 32'h0BEE_F002;
        cpu_q.push_back('{cyc + 4 + 2, 1'b0, 1'b0, 32'h0});
        for (int i = 0; i < 5; i++) begin
            gfx_rd   = 1'b1;
            gfx_addr = cont_addr[i];
            gfx_q.push_back(cont_exp[i]);
            @(posedge clock); #1;
            if (i == 0) begin
                cpu_addr = 10'h3FF; cpu_wdata = 32'h0; cpu_size = 2'd0;
            end
        end
        gfx_rd = 1'b0;
        wait_ack();
        gfx_read(8'h14, 32'h0BEE_F002);

        // Reset during ACCESS abandons the write.
        cpu_access(1'b1, 2'd2, 10'h040, 32'h0BAD_F00D, 1'b0, 1'b0, 32'h0);
        @(posedge clock); #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 2'd2; cpu_addr = 10'h040; cpu_wdata = 32'h55AA_55AA;
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        chk("midrst_gfx_data", gfx_data, 32'h0);
        chk("midrst_cpu_rdata", cpu_rdata, 32'h0);
        chk("midrst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
        chk("midrst_cpu_dropped", {31'd0, cpu_dropped}, 32'd0);
        cpu_req = 1'b0;
        repeat (2) @(posedge clock); #1;
        chk("midrst_ack_low", {31'd0, cpu_ack}, 32'd0);
        chk("midrst_gfx_low", gfx_data, 32'h0);
        reset = 1'b1;
        gfx_read(8'h10, 32'h0BAD_F00D);
        cpu_access(1'b0, 2'd2, 10'h040, 32'h0, 1'b0, 1'b1, 32'h0BAD_F00D);

        // Fill every word with its index, then sweep graphics reads back-to-back.
        for (int i = 0; i < 256; i++) begin
            cpu_access(1'b1, 2'd2, {i[7:0], 2'b00}, 32'(i), 1'b0, 1'b0, 32'h0);
        end
        @(posedge clock); #1;
        for (int i = 0; i < 256; i++) begin
            gfx_rd   = 1'b1;
            gfx_addr = i[7:0];
            gfx_q.push_back(32'(i));
            @(posedge clock); #1;
        end
        gfx_rd = 1'b0;
        chk("sweep_last_0xFF", gfx_data, 32'h0000_00FF);

        // Every expectation must have been consumed.
        repeat (4) @(posedge clock); #1;
        chk("gfx_q_drained", 32'(gfx_q.size()), 32'd0);
        chk("cpu_q_drained", 32'(cpu_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/obj_oam_port.md
OBJ_OAM_PORT -- requirements
Module: obj_oam_port

Interface
REQ-001 Parameters: none. Geometry is fixed at 256 words x 32 bits (1 KB of OAM).
REQ-002 Ports (name, direction, width, meaning):
- clock, in, 1, the single clock.
- reset, in, 1, asynchronous, active-low.
- gfx_rd, in, 1, graphics read strobe.
- gfx_addr, in, 8, graphics word address (OAM byte address bits [9:2]).
- gfx_data, out, 32, graphics read data.
- cpu_req, in, 1, CPU access request, held until acknowledged.
- cpu_we, in, 1, CPU write when 1, read when 0.
- cpu_addr, in, 10, CPU byte address.
- cpu_size, in, 2, access size: 0 = byte, 1 = halfword, 2 = word, 3 = reserved.
- cpu_wdata, in, 32, CPU write data (lane-aligned).
- cpu_rdata, out, 32, CPU read data.
- cpu_ack, out, 1, one-cycle completion pulse.
- cpu_dropped, out, 1, one-cycle pulse when a write is discarded.

Function
REQ-003 The module is the responder for the OBJ lookup path. gfx_data shall present word[gfx_addr] exactly one cycle after gfx_rd is sampled high.
REQ-004 gfx_data shall hold its last value while gfx_rd is low.
REQ-005 Graphics has absolute priority. Any cycle with gfx_rd high shall perform no CPU access.
REQ-006 The CPU FSM states are IDLE, ACCESS and DONE.
REQ-007 IDLE to ACCESS on cpu_req high.
REQ-008 ACCESS stays in ACCESS while gfx_rd is high. ACCESS performs the RAM operation in the first cycle with gfx_rd low, then moves to DONE.
REQ-009 DONE asserts cpu_ack for one cycle and returns to IDLE.
REQ-010 cpu_req must be deasserted or re-presented after the ack. A new request may be accepted in the cycle after DONE.
REQ-011 cpu_addr, cpu_we, cpu_size and cpu_wdata shall be latched on the IDLE to ACCESS transition. Changes while in ACCESS or DONE have no effect.
REQ-012 Word write: write all 4 byte lanes of word cpu_addr[9:2]; cpu_addr[1:0] is ignored.
REQ-013 Halfword write: write lanes {2*cpu_addr[1]+1, 2*cpu_addr[1]} only; cpu_addr[0] is ignored.
REQ-014 Byte write: no RAM change, still acked, and cpu_dropped pulses in the same cycle as cpu_ack (hardware-accurate OAM byte-write behaviour).
REQ-015 Reserved size, write: treated as a byte write (dropped).
REQ-016 Reserved size, read: treated as a word read.
REQ-017 Reads: cpu_rdata shall equal the full word[cpu_addr[9:2]], valid in the cycle cpu_ack is high, and held until the next CPU read completes. The CPU side performs lane selection.
REQ-018 Write-to-read ordering: a gfx_rd of word W in any cycle after the CPU write to W was performed shall return the new data.
REQ-019 A CPU read after a CPU write to the same word shall return the written lanes.
REQ-020 Maximum CPU latency is unbounded under continuous gfx_rd. Minimum latency is 2 cycles, from request sampled to cpu_ack.

Reset
REQ-021 Asserting reset (low), at any time, shall force FSM to IDLE, gfx_data = 0, cpu_rdata = 0, cpu_ack = 0, cpu_dropped = 0 and clear the latched request.
REQ-022 Reset mid-ACCESS shall abandon the pending CPU write with no RAM change and no ack.
REQ-023 RAM contents are not reset.
REQ-024 The first cycle after reset deasserts may accept gfx_rd or cpu_req.

Structure
REQ-025 Shared package obj_pkg holds:
- enum oam_size_t {OAM_BYTE, OAM_HALF, OAM_WORD, OAM_RSVD};
- enum oam_state_t {IDLE, ACCESS, DONE};
- constant OAM_WORDS = 256.
REQ-026 One sub-module, obj_oam_ram: single-port 256x32 synchronous RAM with a 4-bit byte-enable write and a registered read.
REQ-027 The arbiter and FSM live in obj_oam_port, which drives the single RAM port mux.

Verification
REQ-028 Word write then read: CPU word write 0xDEADBEEF @0x010, then gfx_rd addr 0x04 -> gfx_data = 0xDEADBEEF one cycle later; cpu_ack was one pulse 2 cycles after the request.
REQ-029 Halfword lanes: word 0x00000000 @0x020, halfword write 0x1234 @0x022 -> word reads 0x12340000; halfword write 0xABCD @0x023 -> word reads 0xABCD0000.
REQ-030 Byte write dropped: byte write 0xFF @0x030 over 0x11223344 -> word unchanged; cpu_ack and cpu_dropped pulse together.
REQ-031 Contention: gfx_rd high for 5 cycles while cpu_req is held -> no CPU access during those cycles; ack 2 cycles after gfx_rd falls; every gfx_data return is on time and correct.
REQ-032 Reset mid-operation: reset low during ACCESS of write 0x55AA55AA @0x040 -> no ack, word keeps its old value, all outputs 0 while reset is low.
REQ-033 Back-to-back: 256 word writes of the value equal to the index, then a gfx_rd sweep 0x00..0xFF -> each gfx_data equals its address; address 0xFF returns 0xFF (wrap boundary).
